minmax_tracker32: RTL and testbench
===================================

Name: minmax_tracker32

Overview:
- Streaming consumer of the 32-bit magnitude comparison: accepts a frame of FRAME_LEN words over a valid/ready handshake.
- Tracks the running maximum and minimum of the frame, and the index of each.
- At frame end, presents one result record over a second valid/ready handshake.
- Sits downstream of CORDIC datapath stages to extract peak/trough magnitudes per block.

Parameters:
- WIDTH, 32, data word width.
- FRAME_LEN, 16, samples per frame; legal range 2..65535.
- IDX_W, $clog2(FRAME_LEN), width of the index and count fields.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_data valid.
- in_ready  out  1  tracker can accept a sample.
- in_data  in  WIDTH  unsigned sample.
- flush  in  1  single-cycle pulse: close the current frame early.
- out_valid  out  1  result record valid.
- out_ready  in  1  downstream accepts the record.
- out_max  out  WIDTH  largest sample in the frame.
- out_min  out  WIDTH  smallest sample in the frame.
- out_max_idx  out  IDX_W  index of the first occurrence of the max.
- out_min_idx  out  IDX_W  index of the first occurrence of the min.
- out_count  out  IDX_W+1  samples in the frame (FRAME_LEN, or fewer after flush).
- out_all_eq  out  1  every sample in the frame was equal.

Behaviour:
- Reset (async, rst_n=0):
  - state=ACCUM, count=0, in_ready=1.
  - out_valid=0; all out_* data fields=0; out_all_eq=0.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Sample acceptance: a sample is accepted when in_valid&in_ready at a rising edge; index = count before increment.
- First sample (count==0): max=min=in_data; both idx=0; all_eq=1.
- Later samples, unsigned compare against the stored max and min:
  - in_data>max: max and max_idx update.
  - in_data<min: min and min_idx update.
  - Equality with either never updates (first occurrence wins).
  - in_data!=max or in_data!=min: all_eq clears.
- ACCUM->HOLD on the accept of sample FRAME_LEN-1. The registered result is visible and out_valid=1 in the cycle after that accept (latency 1).
- HOLD->ACCUM when out_valid&out_ready; count clears that edge. in_ready=1 the next cycle, so there is one bubble per frame.
- Outputs are stable while out_valid=1 and out_ready=0. in_valid is ignored in HOLD (no acceptance).
- flush in ACCUM:
  - count>0, no simultaneous accept: go to HOLD with out_count=count.
  - count>0, simultaneous accept: the sample is included first, then HOLD with out_count=count+1.
  - count==0 with no accept: ignored.
  - count==0 with an accept: a 1-sample frame is emitted.
- flush in HOLD: ignored.
- Comparison is strictly unsigned over the full WIDTH:
  - 32'h80000000 > 32'h7FFFFFFF.
  - 32'hFFFFFFFF is the largest value.
- Reset mid-frame or mid-HOLD discards the partial frame and pending record immediately; no output is produced.
- Fields are registered only. No combinational path from in_* to out_*.

Decomposition:
- Package minmax_pkg:
  - state enum {ACCUM, HOLD}.
  - cmp_res_t struct {gr, lt, eq}.
  - Default FRAME_LEN constant.
- Two instances of the existing comparator32b (bit-level a0..a31/b0..b31, gr/lt/eq): one for in_data vs max, one for in_data vs min.
- Thin wrapper cmp_word maps WIDTH vectors onto comparator32b ports and returns cmp_res_t.
- The FSM and datapath live in minmax_tracker32.

Test Plan:
- FRAME_LEN=4; send 5,9,2,9, out_ready=1 -> max=9 idx=1, min=2 idx=2, count=4, all_eq=0; out_valid exactly 1 cycle after the 4th accept.
- Send 32'h7FFFFFFF, 32'h80000000, 0, 32'hFFFFFFFF -> max=FFFFFFFF idx=3, min=0 idx=2 (unsigned ordering).
- Send 4×32'h55555555 -> max=min=55555555, both idx=0, all_eq=1.
- Hold out_ready=0 for 10 cycles after a frame while driving in_valid=1 -> in_ready=0, no accept, out_* stable; accept resumes the cycle after out_ready=1.
- Send A,3 then flush coincident with a sample of 1 -> out_count=3, max=A, min=1 idx=2; flush at count==0 with in_valid=0 -> no output.
- Assert rst_n=0 after 2 samples -> out_valid=0 and count=0 immediately (asynchronous); next frame of 4 reports only post-reset samples.

Source files
------------

// File: rtl/minmax_pkg.sv
// Shared types and defaults for the min/max frame tracker.
package minmax_pkg;

  typedef enum logic [0:0] {
    ACCUM,
    HOLD
  } state_e;

  typedef struct packed {
    logic gr;
    logic lt;
    logic eq;
  } cmp_res_t;

  localparam int unsigned DefaultFrameLen = 16;

endpackage

// File: rtl/minmax_tracker32_if.sv
// Sample-in and result-out handshakes of the min/max frame tracker.
interface minmax_tracker32_if
  import minmax_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDX_W = $clog2(DefaultFrameLen)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_max;
  logic [WIDTH-1:0] out_min;
  logic [IDX_W-1:0] out_max_idx;
  logic [IDX_W-1:0] out_min_idx;
  logic [IDX_W:0]   out_count;
  logic             out_all_eq;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_max, out_min, out_max_idx, out_min_idx, out_count,
           out_all_eq
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_max, out_min, out_max_idx, out_min_idx, out_count,
           out_all_eq
  );
endinterface

// File: rtl/cmp_word.sv
// Maps a WIDTH-bit word pair onto comparator32b and packs the result.
module cmp_word
  import minmax_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output cmp_res_t         res
);
  logic [31:0] aw, bw;
  logic        gr, lt, eq;

  // Narrower words are zero-extended so unsigned ordering is preserved.
  assign aw = 32'(a);
  assign bw = 32'(b);

  comparator32b u_cmp (
    .a0 (aw[0]),  .a1 (aw[1]),  .a2 (aw[2]),  .a3 (aw[3]),  .a4 (aw[4]),  .a5 (aw[5]),
    .a6 (aw[6]),  .a7 (aw[7]),  .a8 (aw[8]),  .a9 (aw[9]),  .a10(aw[10]), .a11(aw[11]),
    .a12(aw[12]), .a13(aw[13]), .a14(aw[14]), .a15(aw[15]), .a16(aw[16]), .a17(aw[17]),
    .a18(aw[18]), .a19(aw[19]), .a20(aw[20]), .a21(aw[21]), .a22(aw[22]), .a23(aw[23]),
    .a24(aw[24]), .a25(aw[25]), .a26(aw[26]), .a27(aw[27]), .a28(aw[28]), .a29(aw[29]),
    .a30(aw[30]), .a31(aw[31]),
    .b0 (bw[0]),  .b1 (bw[1]),  .b2 (bw[2]),  .b3 (bw[3]),  .b4 (bw[4]),  .b5 (bw[5]),
    .b6 (bw[6]),  .b7 (bw[7]),  .b8 (bw[8]),  .b9 (bw[9]),  .b10(bw[10]), .b11(bw[11]),
    .b12(bw[12]), .b13(bw[13]), .b14(bw[14]), .b15(bw[15]), .b16(bw[16]), .b17(bw[17]),
    .b18(bw[18]), .b19(bw[19]), .b20(bw[20]), .b21(bw[21]), .b22(bw[22]), .b23(bw[23]),
    .b24(bw[24]), .b25(bw[25]), .b26(bw[26]), .b27(bw[27]), .b28(bw[28]), .b29(bw[29]),
    .b30(bw[30]), .b31(bw[31]),
    .gr (gr),
    .lt (lt),
    .eq (eq)
  );

  assign res = '{gr: gr, lt: lt, eq: eq};
endmodule

// File: rtl/comparator32b.sv
// Bit-level 32-bit unsigned magnitude comparator (a vs b).
module comparator32b (
  input  logic a0,  a1,  a2,  a3,  a4,  a5,  a6,  a7,
  input  logic a8,  a9,  a10, a11, a12, a13, a14, a15,
  input  logic a16, a17, a18, a19, a20, a21, a22, a23,
  input  logic a24, a25, a26, a27, a28, a29, a30, a31,
  input  logic b0,  b1,  b2,  b3,  b4,  b5,  b6,  b7,
  input  logic b8,  b9,  b10, b11, b12, b13, b14, b15,
  input  logic b16, b17, b18, b19, b20, b21, b22, b23,
  input  logic b24, b25, b26, b27, b28, b29, b30, b31,
  output logic gr,
  output logic lt,
  output logic eq
);
  logic [31:0] a, b;

  assign a = {a31, a30, a29, a28, a27, a26, a25, a24, a23, a22, a21, a20, a19, a18, a17, a16,
              a15, a14, a13, a12, a11, a10, a9,  a8,  a7,  a6,  a5,  a4,  a3,  a2,  a1,  a0};
  assign b = {b31, b30, b29, b28, b27, b26, b25, b24, b23, b22, b21, b20, b19, b18, b17, b16,
              b15, b14, b13, b12, b11, b10, b9,  b8,  b7,  b6,  b5,  b4,  b3,  b2,  b1,  b0};

  assign gr = a > b;
  assign lt = a < b;
  assign eq = a == b;
endmodule

// File: rtl/minmax_tracker32.sv
// Per-frame running max/min tracker; emits one registered result record per frame.
module minmax_tracker32
  import minmax_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned FRAME_LEN = DefaultFrameLen,
  parameter int unsigned IDX_W     = $clog2(FRAME_LEN)
) (
  input logic               clk,
  input logic               rst_n,
  minmax_tracker32_if.slave bus
);
  localparam logic [IDX_W:0] LastCount = (IDX_W + 1)'(FRAME_LEN - 1);

  state_e           state_q, state_d;
  logic [IDX_W:0]   count_q, count_d;
  logic [WIDTH-1:0] max_q, max_d, min_q, min_d;
  logic [IDX_W-1:0] max_idx_q, max_idx_d, min_idx_q, min_idx_d;
  logic             all_eq_q, all_eq_d;

  logic [WIDTH-1:0] res_max_q, res_min_q;
  logic [IDX_W-1:0] res_max_idx_q, res_min_idx_q;
  logic [IDX_W:0]   res_count_q;
  logic             res_all_eq_q;

  cmp_res_t cmp_max, cmp_min;
  logic     accept, first, load_res;

  cmp_word #(.WIDTH(WIDTH)) u_cmp_max (.a(bus.in_data), .b(max_q), .res(cmp_max));
  cmp_word #(.WIDTH(WIDTH)) u_cmp_min (.a(bus.in_data), .b(min_q), .res(cmp_min));

  assign accept = (state_q == ACCUM) && bus.in_valid;
  assign first  = (count_q == '0);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    max_d     = max_q;
    min_d     = min_q;
    max_idx_d = max_idx_q;
    min_idx_d = min_idx_q;
    all_eq_d  = all_eq_q;
    load_res  = 1'b0;

    if (accept) begin
      count_d = count_q + (IDX_W + 1)'(1);
      if (first) begin
        max_d     = bus.in_data;
        min_d     = bus.in_data;
        max_idx_d = '0;
        min_idx_d = '0;
        all_eq_d  = 1'b1;
      end else begin
        // Strict compares: ties keep the earlier index.
        if (cmp_max.gr) begin
          max_d     = bus.in_data;
          max_idx_d = count_q[IDX_W-1:0];
        end
        if (cmp_min.lt) begin
          min_d     = bus.in_data;
          min_idx_d = count_q[IDX_W-1:0];
        end
        all_eq_d = all_eq_q && cmp_max.eq && cmp_min.eq;
      end
    end

    unique case (state_q)
      ACCUM: begin
        if ((accept && count_q == LastCount) || (bus.flush && (!first || accept))) begin
          state_d  = HOLD;
          load_res = 1'b1;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = ACCUM;
          count_d = '0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ACCUM;
      count_q       <= '0;
      max_q         <= '0;
      min_q         <= '0;
      max_idx_q     <= '0;
      min_idx_q     <= '0;
      all_eq_q      <= 1'b0;
      res_max_q     <= '0;
      res_min_q     <= '0;
      res_max_idx_q <= '0;
      res_min_idx_q <= '0;
      res_count_q   <= '0;
      res_all_eq_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      max_q     <= max_d;
      min_q     <= min_d;
      max_idx_q <= max_idx_d;
      min_idx_q <= min_idx_d;
      all_eq_q  <= all_eq_d;
      if (load_res) begin
        res_max_q     <= max_d;
        res_min_q     <= min_d;
        res_max_idx_q <= max_idx_d;
        res_min_idx_q <= min_idx_d;
        res_count_q   <= count_d;
        res_all_eq_q  <= all_eq_d;
      end
    end
  end

  assign bus.in_ready    = (state_q == ACCUM);
  assign bus.out_valid   = (state_q == HOLD);
  assign bus.out_max     = res_max_q;
  assign bus.out_min     = res_min_q;
  assign bus.out_max_idx = res_max_idx_q;
  assign bus.out_min_idx = res_min_idx_q;
  assign bus.out_count   = res_count_q;
  assign bus.out_all_eq  = res_all_eq_q;
endmodule

// File: tb/tb_minmax_tracker32.sv
// Self-checking bench for minmax_tracker32 with FRAME_LEN=4: table frames, corner sequences,
// and randomized traffic against a queue-based frame model.
module tb_minmax_tracker32;
  localparam int unsigned FrameLen = 4;

  typedef struct {
    logic [31:0] mx;
    logic [31:0] mn;
    int          mxi;
    int          mni;
    int          cnt;
    bit          eq;
  } rec_t;

  typedef struct {
    logic [31:0] d [4];
    rec_t        exp;
  } vec_t;

  logic clk, rst_n;
  int   tests, failed;

  logic [31:0] frame [$];
  bit          exp_hold;
  rec_t        exp_rec;
  vec_t        tbl [4];

  minmax_tracker32_if #(.WIDTH(32), .IDX_W(2)) bus ();

  minmax_tracker32 #(.WIDTH(32), .FRAME_LEN(FrameLen), .IDX_W(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic rec_t summarise();
    rec_t r;
    r.mx  = frame[0];
    r.mn  = frame[0];
    r.mxi = 0;
    r.mni = 0;
    r.cnt = frame.size();
    r.eq  = 1'b1;
    for (int i = 1; i < frame.size(); i++) begin
      if (frame[i] > r.mx) begin r.mx = frame[i]; r.mxi = i; end
      if (frame[i] < r.mn) begin r.mn = frame[i]; r.mni = i; end
      if (frame[i] != frame[0]) r.eq = 1'b0;
    end
    return r;
  endfunction

  task automatic check_rec(input string tag, input rec_t r);
    check({tag, ".max"},     bus.out_max, r.mx);
    check({tag, ".min"},     bus.out_min, r.mn);
    check({tag, ".max_idx"}, 32'(bus.out_max_idx), r.mxi);
    check({tag, ".min_idx"}, 32'(bus.out_min_idx), r.mni);
    check({tag, ".count"},   32'(bus.out_count), r.cnt);
    check({tag, ".all_eq"},  32'(bus.out_all_eq), 32'(r.eq));
  endtask

  task automatic check_model();
    check("out_valid", 32'(bus.out_valid), 32'(exp_hold));
    check("in_ready", 32'(bus.in_ready), 32'(!exp_hold));
    if (exp_hold) check_rec("model", exp_rec);
  endtask

  // One clock: check at the negedge, drive, let the posedge happen, advance the model.
  task automatic tick(input bit v, input logic [31:0] d, input bit f, input bit r);
    check_model();
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.flush     = f;
    bus.out_ready = r;
    @(posedge clk);
    if (exp_hold) begin
      if (r) exp_hold = 1'b0;
    end else begin
      if (v) frame.push_back(d);
      if ((v && frame.size() == FrameLen) || (f && frame.size() > 0)) begin
        exp_rec = summarise();
        frame.delete();
        exp_hold = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic async_reset();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.in_ready", 32'(bus.in_ready), 32'd1);
    check("rst.out_max", bus.out_max, 32'd0);
    check("rst.out_count", 32'(bus.out_count), 32'd0);
    frame.delete();
    exp_hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tests = 0;
    failed = 0;
    exp_hold = 1'b0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;

    tbl[0].d = '{32'd5, 32'd9, 32'd2, 32'd9};
    tbl[0].exp = '{mx: 32'd9, mn: 32'd2, mxi: 1, mni: 2, cnt: 4, eq: 1'b0};
    tbl[1].d = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF};
    tbl[1].exp = '{mx: 32'hFFFF_FFFF, mn: 32'h0, mxi: 3, mni: 2, cnt: 4, eq: 1'b0};
    tbl[2].d = '{32'h5555_5555, 32'h5555_5555, 32'h5555_5555, 32'h5555_5555};
    tbl[2].exp = '{mx: 32'h5555_5555, mn: 32'h5555_5555, mxi: 0, mni: 0, cnt: 4, eq: 1'b1};
    tbl[3].d = '{32'd3, 32'd3, 32'd1, 32'd1};
    tbl[3].exp = '{mx: 32'd3, mn: 32'd1, mxi: 0, mni: 2, cnt: 4, eq: 1'b0};

    repeat (2) @(negedge clk);
    check("reset.out_valid", 32'(bus.out_valid), 32'd0);
    check("reset.in_ready", 32'(bus.in_ready), 32'd1);
    check_rec("reset", '{mx: 32'd0, mn: 32'd0, mxi: 0, mni: 0, cnt: 0, eq: 1'b0});
    rst_n = 1'b1;
    @(negedge clk);

    // Table frames with out_ready high: record appears one cycle after the 4th accept.
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 4; k++) begin
        if (k == 3) check("tbl.pre_valid", 32'(bus.out_valid), 32'd0);
        tick(1'b1, tbl[t].d[k], 1'b0, 1'b1);
      end
      check("tbl.out_valid", 32'(bus.out_valid), 32'd1);
      check_rec($sformatf("tbl%0d", t), tbl[t].exp);
      tick(1'b0, 32'd0, 1'b0, 1'b1);
    end

    // Backpressure: in_valid held high while the record waits.
    for (int k = 0; k < 4; k++) tick(1'b1, 32'd100 + 32'(k), 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) tick(1'b1, $urandom, 1'b0, 1'b0);
    check("stall.in_ready", 32'(bus.in_ready), 32'd0);
    check_rec("stall", '{mx: 32'd103, mn: 32'd100, mxi: 3, mni: 0, cnt: 4, eq: 1'b0});
    tick(1'b1, 32'hDEAD, 1'b0, 1'b1);
    check("resume.in_ready", 32'(bus.in_ready), 32'd1);
    tick(1'b1, 32'h42, 1'b0, 1'b1);
    tick(1'b0, 32'd0, 1'b1, 1'b0);
    check_rec("resume", '{mx: 32'h42, mn: 32'h42, mxi: 0, mni: 0, cnt: 1, eq: 1'b1});
    tick(1'b0, 32'd0, 1'b0, 1'b1);

    // Flush coincident with a sample.
    tick(1'b1, 32'hA, 1'b0, 1'b1);
    tick(1'b1, 32'h3, 1'b0, 1'b1);
    tick(1'b1, 32'h1, 1'b1, 1'b1);
    check_rec("flush_acc", '{mx: 32'hA, mn: 32'h1, mxi: 0, mni: 2, cnt: 3, eq: 1'b0});
    tick(1'b0, 32'd0, 1'b0, 1'b1);
    // Flush on an empty frame does nothing.
    tick(1'b0, 32'd0, 1'b1, 1'b1);
    check("flush_empty.out_valid", 32'(bus.out_valid), 32'd0);
    // Flush without a sample after two accepts.
    tick(1'b1, 32'd8, 1'b0, 1'b1);
    tick(1'b1, 32'd6, 1'b0, 1'b1);
    tick(1'b0, 32'd0, 1'b1, 1'b1);
    check_rec("flush_noacc", '{mx: 32'd8, mn: 32'd6, mxi: 0, mni: 1, cnt: 2, eq: 1'b0});
    tick(1'b0, 32'd0, 1'b0, 1'b1);
    // Flush with a sample on an empty frame: one-sample record.
    tick(1'b1, 32'd7, 1'b1, 1'b1);
    check_rec("flush_one", '{mx: 32'd7, mn: 32'd7, mxi: 0, mni: 0, cnt: 1, eq: 1'b1});
    tick(1'b0, 32'd0, 1'b0, 1'b1);

    // Reset while a record is pending, then mid-frame.
    for (int k = 0; k < 4; k++) tick(1'b1, 32'd50 - 32'(k), 1'b0, 1'b0);
    async_reset();
    tick(1'b1, 32'd999, 1'b0, 1'b1);
    tick(1'b1, 32'd0, 1'b0, 1'b1);
    async_reset();
    for (int k = 0; k < 4; k++) tick(1'b1, 32'd10 * 32'(k + 1), 1'b0, 1'b1);
    check_rec("post_reset", '{mx: 32'd40, mn: 32'd10, mxi: 3, mni: 0, cnt: 4, eq: 1'b0});
    tick(1'b0, 32'd0, 1'b0, 1'b1);

    // Randomized traffic; narrow data ranges provoke ties and all-equal frames.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] d;
      case ($urandom_range(2, 0))
        0: d = $urandom_range(1, 0);
        1: d = $urandom_range(7, 0);
        default: d = $urandom;
      endcase
      tick(($urandom_range(3, 0) != 0), d, ($urandom_range(9, 0) == 0),
           ($urandom_range(2, 0) != 0));
    end
    check_model();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
